// File: rtl/xinput_cond.sv
// rtl/xinput_cond.sv - front-panel button/switch conditioner with polled register port
//
// Purpose: synchronises the two push-buttons and eight slide switches,
// debounces the buttons (and optionally the switches), produces one-cycle
// press pulses, and keeps sticky press / switch-change flags that firmware
// reads and clears through a small register window.
//
// Optional feature macro: XINPUT_COND_SW_DEBOUNCE_EN
//   defined     - switches go through the same debounce counter as buttons
//   not defined - switches are only synchronised (2-cycle latency)
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   btn_raw    in   2   raw buttons (bit0 = Btn2, bit1 = Btn3), high when pressed
//   sw_raw     in   8   raw slide switches
//   sel        in   1   register select
//   we         in   1   write enable, qualified by sel
//   addr       in   2   register address
//   data_in    in  32   write data
//   data_out   out 32   read data (0 unless sel & ~we)
//   btn_level  out  2   debounced button levels
//   btn_pulse  out  2   one-cycle pulse on debounced press
//   sw_level   out  8   conditioned switch levels
//
// Register map:
//   0: {23'b0, swc, 6'b0, ev[1:0]}  write 1 to bits[1:0] / bit 8 to clear
//   1: {24'b0, sw_level}            read-only
//   2: {30'b0, btn_level}           read-only
//   3: reads 0

module xinput_cond #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  btn_raw,
  input  logic [7:0]  sw_raw,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [1:0]  btn_level,
  output logic [1:0]  btn_pulse,
  output logic [7:0]  sw_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Two-flop synchronisers for every pin.
  logic [1:0] btn_s1_q, btn_s2_q;
  logic [7:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Buttons occupy the low debounce lanes; switches join them only when
  // switch debouncing is built in.
`ifdef XINPUT_COND_SW_DEBOUNCE_EN
  localparam int N_DB = 10;
`else
  localparam int N_DB = 2;
`endif

  logic [N_DB-1:0] db_in;
  logic [N_DB-1:0] db_lvl;

`ifdef XINPUT_COND_SW_DEBOUNCE_EN
  assign db_in = {sw_s2_q, btn_s2_q};
`else
  assign db_in = btn_s2_q;
`endif

  // Per-lane debounce: the count runs only while the synchronised input
  // disagrees with the current level, and any agreement restarts it.
  for (genvar i = 0; i < N_DB; i++) begin : g_db
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (db_in[i] == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        db_d  = db_in[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        db_q  <= db_d;
      end
    end

    assign db_lvl[i] = db_q;
  end

  assign btn_level = db_lvl[1:0];

`ifdef XINPUT_COND_SW_DEBOUNCE_EN
  assign sw_level = db_lvl[9:2];
`else
  assign sw_level = sw_s2_q;
`endif

  // Delayed copies for edge detection; both reset to 0 so leaving reset
  // never looks like an edge.
  logic [1:0] btn_dly_q;
  logic [7:0] sw_dly_q;
  logic       sw_chg;

  assign btn_pulse = btn_level & ~btn_dly_q;
  assign sw_chg    = |(sw_level ^ sw_dly_q);

  // Sticky flags: a new event in the same cycle as a W1C keeps the flag set.
  logic       wr0;
  logic [1:0] ev_q, ev_d;
  logic       swc_q, swc_d;

  assign wr0 = sel && we && (addr == 2'd0);

  always_comb begin
    ev_d  = ev_q;
    swc_d = swc_q;
    if (wr0) begin
      ev_d  = ev_q & ~data_in[1:0];
      swc_d = swc_q & ~data_in[8];
    end
    ev_d  = ev_d | btn_pulse;
    swc_d = swc_d | sw_chg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_dly_q <= '0;
      sw_dly_q  <= '0;
      ev_q      <= '0;
      swc_q     <= 1'b0;
    end else begin
      btn_dly_q <= btn_level;
      sw_dly_q  <= sw_level;
      ev_q      <= ev_d;
      swc_q     <= swc_d;
    end
  end

  // Combinational read port; reads have no side effects.
  always_comb begin
    data_out = '0;
    if (sel && !we) begin
      case (addr)
        2'd0:    data_out = {23'b0, swc_q, 6'b0, ev_q};
        2'd1:    data_out = {24'b0, sw_level};
        2'd2:    data_out = {30'b0, btn_level};
        default: data_out = '0;
      endcase
    end
  end

  // Only the W1C bits of data_in matter.
  logic unused_data_in;
  assign unused_data_in = ^{data_in[31:9], data_in[7:2]};

endmodule

// File: tb/tb_xinput_cond.sv
// tb/tb_xinput_cond.sv - self-checking bench for xinput_cond
module tb_xinput_cond;

  localparam int DB    = 4;
  localparam int CNT_W = 3;
`ifdef XINPUT_COND_SW_DEBOUNCE_EN
  localparam int SW_LAT = 2 + DB;
`else
  localparam int SW_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  btn_raw;
  logic [7:0]  sw_raw;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [1:0]  btn_level;
  logic [1:0]  btn_pulse;
  logic [7:0]  sw_level;

  int checks = 0;
  int errors = 0;

  xinput_cond #(.DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .sw_level  (sw_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a debounced level flips once the raw samples that reached the
  // synchroniser output on the last DB edges all disagree with it.
  // hist[k] = raw value sampled k edges ago (hist[0] = this edge).
  logic [1:0] bh [0:DB+1];
  logic [7:0] sh [0:DB+1];
  logic [1:0] m_db = '0, m_db_prev = '0, m_ev = '0, m_pnow;
  logic [7:0] m_sw = '0, m_sw_prev = '0;
  logic       m_swc = 1'b0, m_wr0, m_flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= DB + 1; k++) begin
        bh[k] = '0;
        sh[k] = '0;
      end
      m_db = '0; m_db_prev = '0; m_ev = '0;
      m_sw = '0; m_sw_prev = '0; m_swc = 1'b0;
    end else begin
      m_pnow = m_db & ~m_db_prev;
      m_wr0  = sel && we && (addr == 2'd0);
      m_ev   = (m_ev & ~(m_wr0 ? data_in[1:0] : 2'b00)) | m_pnow;
      m_swc  = (m_swc & ~(m_wr0 & data_in[8])) | (m_sw != m_sw_prev);
      m_db_prev = m_db;
      m_sw_prev = m_sw;
      for (int k = DB + 1; k > 0; k--) begin
        bh[k] = bh[k-1];
        sh[k] = sh[k-1];
      end
      bh[0] = btn_raw;
      sh[0] = sw_raw;
      for (int b = 0; b < 2; b++) begin
        m_flip = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (bh[k][b] == m_db[b]) m_flip = 1'b0;
        if (m_flip) m_db[b] = ~m_db[b];
      end
`ifdef XINPUT_COND_SW_DEBOUNCE_EN
      for (int b = 0; b < 8; b++) begin
        m_flip = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (sh[k][b] == m_sw[b]) m_flip = 1'b0;
        if (m_flip) m_sw[b] = ~m_sw[b];
      end
`else
      m_sw = sh[1];
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [31:0] e_dout;
  always @(negedge clk) begin
    e_dout = '0;
    if (sel && !we) begin
      case (addr)
        2'd0:    e_dout = {23'b0, m_swc, 6'b0, m_ev};
        2'd1:    e_dout = {24'b0, m_sw};
        2'd2:    e_dout = {30'b0, m_db};
        default: e_dout = '0;
      endcase
    end
    chk("m_btn_level", 32'(btn_level), 32'(m_db));
    chk("m_btn_pulse", 32'(btn_pulse), 32'(m_db & ~m_db_prev));
    chk("m_sw_level", 32'(sw_level), 32'(m_sw));
    chk("m_data_out", data_out, e_dout);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    cyc();
    sel = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
  endtask

  logic bounce [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; btn_raw = 2'b11; sw_raw = 8'hA5;
    sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;

    // Reset with inputs held.
    repeat (3) cyc();
    #1;
    chk("rst_btn_level", 32'(btn_level), 32'h0);
    chk("rst_btn_pulse", 32'(btn_pulse), 32'h0);
    chk("rst_sw_level", 32'(sw_level), 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    rst = 1'b0;
    repeat (5) cyc();
    #1 chk("held_pre_level", 32'(btn_level), 32'h0);
    cyc();
    #1 chk("held_level", 32'(btn_level), 32'h3);
    chk("held_pulse", 32'(btn_pulse), 32'h3);
    cyc();
    #1 chk("held_pulse_gone", 32'(btn_pulse), 32'h0);
    rd(2'd0);
    chk("held_addr0", data_out, 32'h103);

    // Clear everything, release buttons: level falls 6 cycles later, no pulse.
    wr(2'd0, 32'h103);
    btn_raw = 2'b00;
    repeat (5) cyc();
    #1 chk("release_hold", 32'(btn_level), 32'h3);
    cyc();
    #1 chk("release_level", 32'(btn_level), 32'h0);
    rd(2'd0);
    chk("cleared_addr0", data_out, 32'h0);

    // Clean press of btn 0.
    btn_raw = 2'b01;
    repeat (5) cyc();
    #1 chk("press0_nopulse", 32'(btn_pulse), 32'h0);
    cyc();
    #1 chk("press0_pulse", 32'(btn_pulse), 32'h1);
    cyc();
    #1 chk("press0_single", 32'(btn_pulse), 32'h0);
    rd(2'd0);
    chk("press0_ev", data_out, 32'h1);
    wr(2'd0, 32'h1);
    btn_raw = 2'b00;
    repeat (6) cyc();
    #1 chk("press0_release", 32'(btn_level), 32'h0);

    // Bouncing btn 1: 1,0,1,1,0 then steady 1.
    for (int i = 0; i < 5; i++) begin
      btn_raw[1] = bounce[i];
      cyc();
    end
    btn_raw[1] = 1'b1;
    repeat (5) cyc();
    #1 chk("bounce_pre_level", 32'(btn_level), 32'h0);
    cyc();
    #1 chk("bounce_level", 32'(btn_level), 32'h2);
    chk("bounce_pulse", 32'(btn_pulse), 32'h2);
    cyc();
    rd(2'd0);
    chk("bounce_ev", data_out, 32'h2);
    wr(2'd0, 32'h2);
    btn_raw = 2'b00;
    repeat (6) cyc();

    // Set beats clear: W1C of ev[0] lands on the edge a new pulse sets it.
    btn_raw = 2'b01;
    repeat (7) cyc();
    btn_raw = 2'b00;
    repeat (6) cyc();
    btn_raw = 2'b01;
    repeat (6) cyc();
    #1 chk("prio_pulse", 32'(btn_pulse), 32'h1);
    wr(2'd0, 32'h1);
    rd(2'd0);
    chk("prio_set_wins", data_out, 32'h1);
    wr(2'd0, 32'h1);
    rd(2'd0);
    chk("prio_cleared", data_out, 32'h0);
    btn_raw = 2'b00;
    repeat (6) cyc();

    // Switch path and swc flag.
    sw_raw = 8'h00;
    repeat (8) cyc();
    wr(2'd0, 32'h100);
    sw_raw = 8'h3C;
    rd(2'd1);
    repeat (SW_LAT - 1) cyc();
    #1 chk("sw_pre", data_out, 32'h0);
    cyc();
    #1 chk("sw_addr1", data_out, 32'h3C);
    repeat (2) cyc();
    rd(2'd0);
    chk("swc_set", data_out, 32'h100);
    wr(2'd1, 32'hFF);
    rd(2'd1);
    chk("addr1_ro", data_out, 32'h3C);
    wr(2'd0, 32'h100);
    rd(2'd0);
    chk("swc_cleared", data_out, 32'h0);
    rd(2'd3);
    chk("addr3_zero", data_out, 32'h0);
    rd(2'd2);
    chk("addr2_btn", data_out, 32'h0);
    sel = 1'b0;

    // Reset while btn 0 counter is at 3.
    btn_raw = 2'b01;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    #1 chk("midrst_level", 32'(btn_level), 32'h0);
    chk("midrst_sw", 32'(sw_level), 32'h0);
    rst = 1'b0;
    repeat (5) cyc();
    #1 chk("midrst_nopulse", 32'(btn_pulse), 32'h0);
    chk("midrst_nolevel", 32'(btn_level), 32'h0);
    cyc();
    #1 chk("midrst_pulse", 32'(btn_pulse), 32'h1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
